// File: rtl/decode_pkg.sv
// Shared decode-stage definitions: opcode map, FIFO entry payload, legality helper.
package decode_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned OPC_W = 5;

  // Major opcodes, instr[6:2]
  localparam logic [OPC_W-1:0] OPC_LUI    = 5'b01101;
  localparam logic [OPC_W-1:0] OPC_AUIPC  = 5'b00101;
  localparam logic [OPC_W-1:0] OPC_JAL    = 5'b11011;
  localparam logic [OPC_W-1:0] OPC_JALR   = 5'b11001;
  localparam logic [OPC_W-1:0] OPC_LOAD   = 5'b00000;
  localparam logic [OPC_W-1:0] OPC_OPIMM  = 5'b00100;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 5'b11000;
  localparam logic [OPC_W-1:0] OPC_STORE  = 5'b01000;
  localparam logic [OPC_W-1:0] OPC_SYSTEM = 5'b11100;
  localparam logic [OPC_W-1:0] OPC_FLOAD  = 5'b00001;
  localparam logic [OPC_W-1:0] OPC_FSTORE = 5'b01001;
  localparam logic [OPC_W-1:0] OPC_OP     = 5'b01100;
  localparam logic [OPC_W-1:0] OPC_FENCE  = 5'b00011;

  // One buffered fetch slot
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } entry_t;

  // Uncompressed encoding with a supported major opcode
  function automatic logic is_legal(input logic [XLEN-1:0] instr);
    logic ok;
    ok = 1'b0;
    case (instr[6:2])
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_LOAD, OPC_OPIMM, OPC_BRANCH,
      OPC_STORE, OPC_SYSTEM, OPC_FLOAD, OPC_FSTORE, OPC_OP, OPC_FENCE: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok && (instr[1:0] == 2'b11);
  endfunction

endpackage

// File: rtl/decode_fifo.sv
// Circular instruction buffer with valid/ready on both sides and flush.
module decode_fifo
  import decode_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   push_valid,
  output logic   push_ready,
  input  entry_t push_data,
  input  logic   flush,
  output logic   pop_valid,
  input  logic   pop_ready,
  output entry_t head
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  entry_t           mem [DEPTH];
  logic             push;
  logic             pop;

  // Handshake decode from registered count only (no path from pop_ready to push_ready)
  assign push_ready = (count != CNT_W'(DEPTH));
  assign pop_valid  = (count != '0) && !flush;
  assign push       = push_valid && push_ready && !flush;
  assign pop        = pop_valid && pop_ready;
  assign head       = mem[rd_ptr];

  // Pointer, count and storage update; reset beats flush beats push/pop
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/imm_decoder.sv
// Immediate extraction from instr[31:2]; bit k of instr maps to original bit k+2.
module imm_decoder
  import decode_pkg::*;
(
  input  logic [XLEN-3:0] instr,
  output logic [XLEN-1:0] imm
);

  // Select immediate format from the major opcode
  always_comb begin
    imm = '0;
    case (instr[4:0])
      OPC_LUI, OPC_AUIPC:
        imm = {instr[29:10], 12'b0};
      OPC_JAL:
        imm = {{12{instr[29]}}, instr[17:10], instr[18], instr[28:19], 1'b0};
      OPC_JALR, OPC_LOAD, OPC_OPIMM, OPC_FLOAD:
        imm = {{20{instr[29]}}, instr[29:18]};
      OPC_BRANCH:
        imm = {{20{instr[29]}}, instr[5], instr[28:23], instr[9:6], 1'b0};
      OPC_STORE, OPC_FSTORE:
        imm = {{21{instr[29]}}, instr[28:23], instr[9:5]};
      OPC_SYSTEM:
        imm = {27'b0, instr[17:13]};
      default:
        imm = '0;
    endcase
  end

endmodule

// File: rtl/decode_ctrl.sv
// Decode-stage controller: fetch buffer, head immediate decode, stall counter.
// Optional opcode legality check enabled by defining DECODE_ILLEGAL_CHK_EN.
module decode_ctrl
  import decode_pkg::*;
#(
  parameter int unsigned DEPTH       = 2,
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   fetch_valid_i,
  output logic                   fetch_ready_o,
  input  logic [XLEN-1:0]        fetch_instr_i,
  input  logic [XLEN-1:0]        fetch_pc_i,
  input  logic                   flush_i,
  output logic                   ex_valid_o,
  input  logic                   ex_ready_i,
  output logic [XLEN-1:0]        ex_instr_o,
  output logic [XLEN-1:0]        ex_pc_o,
  output logic [XLEN-1:0]        ex_imm_o,
  output logic                   illegal_o,
  output logic [STALL_CNT_W-1:0] stall_cnt_o
);

  entry_t push_data;
  entry_t head;

  assign push_data = '{instr: fetch_instr_i, pc: fetch_pc_i};

  decode_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk        (clk_i),
    .reset      (reset_i),
    .push_valid (fetch_valid_i),
    .push_ready (fetch_ready_o),
    .push_data  (push_data),
    .flush      (flush_i),
    .pop_valid  (ex_valid_o),
    .pop_ready  (ex_ready_i),
    .head       (head)
  );

  imm_decoder u_imm (
    .instr (head.instr[XLEN-1:2]),
    .imm   (ex_imm_o)
  );

  assign ex_instr_o = head.instr;
  assign ex_pc_o    = head.pc;

`ifdef DECODE_ILLEGAL_CHK_EN
  assign illegal_o = ex_valid_o && !is_legal(head.instr);
`else
  assign illegal_o = 1'b0;
`endif

  // Saturating count of cycles execute holds off a valid head; survives flush
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      stall_cnt_o <= '0;
    end else if (ex_valid_o && !ex_ready_i && (stall_cnt_o != '1)) begin
      stall_cnt_o <= stall_cnt_o + STALL_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_decode_ctrl.sv
// Directed, table-driven bench for decode_ctrl (default DEPTH=2).
module tb_decode_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [31:0] fetch_instr;
  logic [31:0] fetch_pc;
  logic        flush;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_instr;
  logic [31:0] ex_pc;
  logic [31:0] ex_imm;
  logic        illegal;
  logic [15:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  decode_ctrl #(.DEPTH(2), .STALL_CNT_W(16)) dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .fetch_valid_i (fetch_valid),
    .fetch_ready_o (fetch_ready),
    .fetch_instr_i (fetch_instr),
    .fetch_pc_i    (fetch_pc),
    .flush_i       (flush),
    .ex_valid_o    (ex_valid),
    .ex_ready_i    (ex_ready),
    .ex_instr_o    (ex_instr),
    .ex_pc_o       (ex_pc),
    .ex_imm_o      (ex_imm),
    .illegal_o     (illegal),
    .stall_cnt_o   (stall_cnt)
  );

  typedef struct {
    logic        fv;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        fl;
    logic        er;
    logic        x_fr;
    logic        x_ev;
    logic [31:0] x_instr;
    logic [31:0] x_pc;
    logic [31:0] x_imm;
    logic [15:0] x_stall;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  localparam logic [31:0] ADDI = 32'h0050_0093, LUI = 32'h1234_5037, BEQ = 32'hFE00_0EE3;
  localparam logic [31:0] IA = 32'h00A0_0113, IB = 32'h00F0_0193, IC = 32'h0140_0213;
  localparam logic [31:0] ID = 32'h0010_0293, IE = 32'h0020_0313, IF = 32'h0030_0393;
  localparam logic [31:0] IG = 32'h0040_0413, IH = 32'h0050_0493, BAD = 32'h0000_007F;

`ifdef DECODE_ILLEGAL_CHK_EN
  localparam logic ILL_EXP = 1'b1;
`else
  localparam logic ILL_EXP = 1'b0;
`endif

  function automatic vec_t mk(input logic fv, input logic [31:0] in, input logic [31:0] pc,
                              input logic fl, input logic er, input logic fr, input logic ev,
                              input logic [31:0] xi, input logic [31:0] xp,
                              input logic [31:0] xm, input logic [15:0] xs);
    vec_t v;
    v.fv = fv; v.instr = in; v.pc = pc; v.fl = fl; v.er = er;
    v.x_fr = fr; v.x_ev = ev; v.x_instr = xi; v.x_pc = xp; v.x_imm = xm; v.x_stall = xs;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rst, input logic fv, input logic [31:0] in,
                       input logic [31:0] pc, input logic fl, input logic er);
    reset = rst; fetch_valid = fv; fetch_instr = in; fetch_pc = pc; flush = fl; ex_ready = er;
  endtask

  task automatic check_all(input string tag, input logic fr, input logic ev,
                           input logic [31:0] xi, input logic [31:0] xp,
                           input logic [31:0] xm, input logic ill, input logic [15:0] xs);
    chk({tag, ".fetch_ready"}, 32'(fetch_ready), 32'(fr));
    chk({tag, ".ex_valid"},    32'(ex_valid),    32'(ev));
    chk({tag, ".ex_instr"},    ex_instr,         xi);
    chk({tag, ".ex_pc"},       ex_pc,            xp);
    chk({tag, ".ex_imm"},      ex_imm,           xm);
    chk({tag, ".illegal"},     32'(illegal),     32'(ill));
    chk({tag, ".stall_cnt"},   32'(stall_cnt),   32'(xs));
  endtask

  // Advance one full cycle: cross the active edge, land on the next negedge
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    vecs[0]  = mk(1, ADDI, 32'h100, 0, 1, 1, 0, 32'h0, 32'h0,   32'h0,         0);
    vecs[1]  = mk(0, 0,    0,       0, 0, 1, 1, ADDI,  32'h100, 32'h5,         0);
    vecs[2]  = mk(1, LUI,  32'h104, 0, 1, 1, 1, ADDI,  32'h100, 32'h5,         1);
    vecs[3]  = mk(1, BEQ,  32'h108, 0, 1, 1, 1, LUI,   32'h104, 32'h1234_5000, 1);
    vecs[4]  = mk(0, 0,    0,       0, 1, 1, 1, BEQ,   32'h108, 32'hFFFF_FFFC, 1);
    vecs[5]  = mk(1, IA,   32'h200, 0, 0, 1, 0, LUI,   32'h104, 32'h1234_5000, 1);
    vecs[6]  = mk(1, IB,   32'h204, 0, 0, 1, 1, IA,    32'h200, 32'hA,         1);
    vecs[7]  = mk(1, IC,   32'h208, 0, 0, 0, 1, IA,    32'h200, 32'hA,         2);
    vecs[8]  = mk(1, IC,   32'h208, 0, 0, 0, 1, IA,    32'h200, 32'hA,         3);
    vecs[9]  = mk(1, IC,   32'h208, 0, 1, 0, 1, IA,    32'h200, 32'hA,         4);
    vecs[10] = mk(1, IC,   32'h208, 0, 1, 1, 1, IB,    32'h204, 32'hF,         4);
    vecs[11] = mk(0, 0,    0,       0, 1, 1, 1, IC,    32'h208, 32'h14,        4);
    vecs[12] = mk(1, ID,   32'h300, 0, 0, 1, 0, IB,    32'h204, 32'hF,         4);
    vecs[13] = mk(1, IE,   32'h304, 0, 0, 1, 1, ID,    32'h300, 32'h1,         4);
    vecs[14] = mk(1, IF,   32'h308, 1, 1, 0, 0, ID,    32'h300, 32'h1,         5);
    vecs[15] = mk(0, 0,    0,       0, 1, 1, 0, ID,    32'h300, 32'h1,         5);
    vecs[16] = mk(1, IG,   32'h400, 1, 1, 1, 0, ID,    32'h300, 32'h1,         5);
    vecs[17] = mk(1, IG,   32'h400, 0, 0, 1, 0, ID,    32'h300, 32'h1,         5);
    vecs[18] = mk(1, IH,   32'h404, 1, 0, 1, 0, IG,    32'h400, 32'h4,         5);
    vecs[19] = mk(0, 0,    0,       0, 0, 1, 0, IG,    32'h400, 32'h4,         5);

    drive(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    tick();
    check_all("reset", 1, 0, 0, 0, 0, 0, 0);

    // Table: inputs applied at negedge, outputs sampled 1 time unit later
    for (int i = 0; i < NV; i++) begin
      drive(0, vecs[i].fv, vecs[i].instr, vecs[i].pc, vecs[i].fl, vecs[i].er);
      #1;
      check_all($sformatf("vec%0d", i), vecs[i].x_fr, vecs[i].x_ev, vecs[i].x_instr,
                vecs[i].x_pc, vecs[i].x_imm, 1'b0, vecs[i].x_stall);
      tick();
    end

    // Unsupported opcode: flagged (when checking is built), imm 0, still pops
    drive(0, 1, BAD, 32'h500, 0, 0);
    tick();
    drive(0, 1, ADDI, 32'h504, 0, 1);
    #1;
    check_all("bad_head", 1, 1, BAD, 32'h500, 32'h0, ILL_EXP, 5);
    tick();
    drive(0, 0, 0, 0, 0, 1);
    #1;
    check_all("good_after_bad", 1, 1, ADDI, 32'h504, 32'h5, 1'b0, 5);
    tick();

    // Fill with two entries, stall up to 7, then reset mid-operation
    drive(0, 1, IA, 32'h600, 0, 0);
    tick();
    drive(0, 1, IB, 32'h604, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    tick();
    #1;
    check_all("pre_reset", 0, 1, IA, 32'h600, 32'hA, 1'b0, 7);
    drive(1, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    #1;
    check_all("post_reset", 1, 0, 0, 0, 0, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_ctrl.md
# decode_ctrl

Decode-stage controller between instruction fetch and execute. Buffers fetched instructions in a small FIFO with valid/ready handshakes on both sides. Runs the head entry through the existing `imm_decoder`, counts execute-side stall cycles, and drops all buffered work on a pipeline flush.

## Interface
- `DEPTH`, 2: FIFO entries; power of two, at least 2.
- `STALL_CNT_W`, 16: width of the stall counter.

- `clk_i`  in  1  core clock.
- `reset_i`  in  1  synchronous, active-high reset.
- `fetch_valid_i`  in  1  fetch presents an instruction.
- `fetch_ready_o`  out  1  controller accepts the instruction this cycle.
- `fetch_instr_i`  in  32  instruction word.
- `fetch_pc_i`  in  32  PC of the instruction.
- `flush_i`  in  1  branch/trap flush; kills all buffered entries.
- `ex_valid_o`  out  1  head entry valid toward execute.
- `ex_ready_i`  in  1  execute consumes the head entry.
- `ex_instr_o`  out  32  head instruction.
- `ex_pc_o`  out  32  head PC.
- `ex_imm_o`  out  32  decoded immediate of the head instruction.
- `illegal_o`  out  1  head opcode is unsupported (feature-gated; see Configuration).
- `stall_cnt_o`  out  `STALL_CNT_W`  saturating count of execute backpressure cycles.

## Operation
- Circular FIFO with write pointer, read pointer and count; each entry holds {instr, pc}.
- Push = `fetch_valid_i & fetch_ready_o & !flush_i`.
- Pop = `ex_valid_o & ex_ready_i`.
- `fetch_ready_o = (count != DEPTH)`. It is registered-state only, with no combinational path from `ex_ready_i`.
- `ex_valid_o = (count != 0) & !flush_i`.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- Pointers wrap modulo `DEPTH`.
- Flush: count, write pointer and read pointer go to 0 on the next edge. A push offered in the flush cycle is dropped. Nothing is popped in the flush cycle, because `ex_valid_o` is 0.
- `ex_instr_o` and `ex_pc_o` reflect the head entry. When the FIFO is empty they show the stale head contents; consumers must gate them with `ex_valid_o`.
- `ex_imm_o` is the `imm_decoder` output for the head, fed with `instr[31:2]`:
  - U: lui, auipc.
  - J: jal.
  - I: jalr, load, op-imm, fp-load.
  - B: branch.
  - S: store, fp-store.
  - CSR: zero-extended `instr[19:15]`.
  - All other opcodes: 0.
- Stall counter: increments on `ex_valid_o & !ex_ready_i`, saturates at all-ones, and is not cleared by flush.

## Timing
- Reset values: count 0, both pointers 0, `fetch_ready_o`=1, `ex_valid_o`=0, `ex_instr_o`=0, `ex_pc_o`=0, `ex_imm_o`=0, `illegal_o`=0, `stall_cnt_o`=0.
- FIFO storage is reset to zero.
- Latency: an instruction accepted at edge N is presented with `ex_valid_o`=1 in cycle N+1.
- Throughput: one instruction per cycle when `ex_ready_i` is held high.
- Full FIFO: `fetch_ready_o`=0 until a pop occurs. Ready returns the cycle after the pop edge.
- Reset mid-operation: all state returns to reset values at the edge; buffered entries are lost.
- Reset has priority over flush, and flush has priority over push and pop.

## Configuration
- `DECODE_ILLEGAL_CHK_EN` defined:
  - `illegal_o = ex_valid_o & !legal(head)`.
  - legal requires `instr[1:0]==2'b11` and `instr[6:2]` in {01101, 00101, 11011, 11001, 00000, 00100, 11000, 01000, 11100, 00001, 01001, 01100, 00011}.
  - An illegal entry still pops normally; execute raises the trap.
- `DECODE_ILLEGAL_CHK_EN` undefined: `illegal_o` tied to 0 and no check logic is built.

## Structure
- Shared package `decode_pkg`:
  - opcode constants (`OPC_LUI`, `OPC_AUIPC`, `OPC_JAL`, `OPC_JALR`, `OPC_LOAD`, `OPC_OPIMM`, `OPC_BRANCH`, `OPC_STORE`, `OPC_SYSTEM`, `OPC_FLOAD`, `OPC_FSTORE`, `OPC_OP`, `OPC_FENCE`);
  - a struct type for one FIFO entry.
- One sub-module, `decode_fifo`: pointers, count, storage, flush.
- `decode_ctrl` instantiates `decode_fifo` and `imm_decoder`, and adds the stall counter and the legality check.

## Test plan
- Reset, then push `addi x1,x0,5` (0x00500093) with PC 0x100 → next cycle `ex_valid_o`=1, `ex_pc_o`=0x100, `ex_imm_o`=0x00000005.
- Stream `lui` 0x12345037 then `beq x0,x0,-4` 0xFE000EE3 with `ex_ready_i`=1 → back-to-back outputs with imm 0x12345000 then 0xFFFFFFFC, and `fetch_ready_o` stays 1.
- Hold `ex_ready_i`=0 and push 3 instructions → `fetch_ready_o`=0 after 2 accepted; `stall_cnt_o` advances by 1 per cycle. Release → instructions drain in order, with no loss or duplication.
- Full FIFO, assert `flush_i` for 1 cycle together with `fetch_valid_i` → `ex_valid_o`=0 that cycle, count=0 next cycle, and the offered instruction is dropped.
- With `DECODE_ILLEGAL_CHK_EN`, push 0x0000007F → `illegal_o`=1, imm=0. Then push 0x00500093 → `illegal_o`=0. Without the macro, `illegal_o`=0 throughout.
- Assert `reset_i` while the FIFO holds 2 entries and stall count = 7 → next cycle all outputs are at their reset values.
